sp_ram_bist: RTL

//  March C- built-in self-test initiator for one sp_ram_wrap instance. Drives
//  the RAM port (en/addr/wdata/we/be) and checks rdata. The parent muxes the
//  RAM port to this block while bist_active_o=1 and to the core otherwise.

---
 rtl/sp_ram_bist_if.sv | 23 ++
 rtl/sp_ram_bist.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_bist_if.sv
// rtl/sp_ram_bist_if.sv - RAM port bundle between the March C- BIST initiator and sp_ram_wrap
//
// Signals (master = BIST initiator, slave = RAM):
//   en     master->slave  1             RAM enable
//   addr   master->slave  ADDR_WIDTH    byte address, [1:0]=0
//   wdata  master->slave  DATA_WIDTH    write data
//   we     master->slave  1             write enable
//   be     master->slave  DATA_WIDTH/8  byte enables
//   rdata  slave->master  DATA_WIDTH    read data, valid one cycle after a read
interface sp_ram_bist_if #(
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 32
);
   logic                      en;
   logic [ADDR_WIDTH-1:0]     addr;
   logic [DATA_WIDTH-1:0]     wdata;
   logic                      we;
   logic [DATA_WIDTH/8-1:0]   be;
   logic [DATA_WIDTH-1:0]     rdata;

   modport master (output en, output addr, output wdata, output we, output be, input rdata);
   modport slave  (input en, input addr, input wdata, input we, input be, output rdata);
endinterface

// File: rtl/sp_ram_bist.sv
// rtl/sp_ram_bist.sv - March C- built-in self-test initiator for one sp_ram_wrap instance
//
// Runs M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0);
// M5 up(r0) over every word, reporting pass/fail and the first failing word.
//
// Ports:
//   clk            clock
//   rstn_i         asynchronous active-low reset
//   start_i        run request, honoured only in IDLE/DONE
//   bist_active_o  BIST owns the RAM port
//   done_o         test finished (level, held in DONE)
//   fail_o         sticky mismatch flag
//   fail_addr_o    word address of the first mismatch
//   ram            RAM port (master side)
module sp_ram_bist #(
   parameter int RAM_SIZE     = 32768,
   parameter int ADDR_WIDTH   = $clog2(RAM_SIZE),
   parameter int DATA_WIDTH   = 32,
   parameter int STOP_ON_FAIL = 0
) (
   input  logic                  clk,
   input  logic                  rstn_i,
   input  logic                  start_i,
   output logic                  bist_active_o,
   output logic                  done_o,
   output logic                  fail_o,
   output logic [ADDR_WIDTH-3:0] fail_addr_o,
   sp_ram_bist_if.master         ram
);
   localparam int BE_W      = DATA_WIDTH / 8;
   localparam int NUM_WORDS = RAM_SIZE / BE_W;
   localparam int WAW       = ADDR_WIDTH - 2;
   localparam logic [WAW-1:0] LAST = WAW'(NUM_WORDS - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WR    = 3'd1;
   localparam logic [2:0] S_RW    = 3'd2;
   localparam logic [2:0] S_RD    = 3'd3;
   localparam logic [2:0] S_FINAL = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   // state_q/elem_q/word_q/rd_q describe the RAM operation on the port this cycle
   logic [2:0]            state_q, state_d;
   logic [2:0]            elem_q, elem_d;
   logic [WAW-1:0]        word_q, word_d;
   logic                  rd_q, rd_d;
   logic                  chk_valid_q, chk_valid_d;
   logic [DATA_WIDTH-1:0] exp_q, exp_d;
   logic [WAW-1:0]        chk_addr_q, chk_addr_d;
   logic                  fail_q, fail_d;
   logic [WAW-1:0]        fail_addr_q, fail_addr_d;
   logic                  done_q, done_d;
   logic                  active_q, active_d;
   logic                  en_q, en_d;
   logic                  we_q, we_d;
   logic [BE_W-1:0]       be_q, be_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

   logic mismatch, stop, up, term, cur_read;

   assign mismatch = chk_valid_q && (ram.rdata != exp_q);
   assign stop     = mismatch && (STOP_ON_FAIL != 0);
   assign up       = (elem_q == 3'd1) || (elem_q == 3'd2);
   assign term     = up ? (word_q == LAST) : (word_q == '0);
   assign cur_read = (state_q == S_RD) || ((state_q == S_RW) && rd_q);

   always_comb begin
      state_d     = state_q;
      elem_d      = elem_q;
      word_d      = word_q;
      rd_d        = rd_q;
      fail_d      = fail_q;
      fail_addr_d = fail_addr_q;
      // A read this cycle arms the compare that runs against rdata next cycle.
      // M2/M4 read all-ones; M1/M3/M5 read all-zeros.
      chk_valid_d = cur_read && !stop;
      exp_d       = ((state_q == S_RW) && !elem_q[0]) ? '1 : '0;
      chk_addr_d  = word_q;

      if (mismatch) begin
         fail_d = 1'b1;
         if (!fail_q) fail_addr_d = chk_addr_q;
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_d     = S_WR;
               elem_d      = '0;
               word_d      = '0;
               rd_d        = 1'b0;
               fail_d      = 1'b0;
               fail_addr_d = '0;
            end
         end
         S_WR: begin
            if (word_q == LAST) begin
               state_d = S_RW;
               elem_d  = 3'd1;
               word_d  = '0;
               rd_d    = 1'b1;
            end else begin
               word_d = word_q + WAW'(1);
            end
         end
         S_RW: begin
            if (rd_q) begin
               rd_d = 1'b0;
            end else begin
               // the write closes the word; the element advances on its terminal word
               rd_d = 1'b1;
               if (term) begin
                  if (elem_q == 3'd4) begin
                     state_d = S_RD;
                     word_d  = '0;
                  end else begin
                     elem_d = elem_q + 3'd1;
                     word_d = (elem_q == 3'd1) ? '0 : LAST;
                  end
               end else begin
                  word_d = up ? word_q + WAW'(1) : word_q - WAW'(1);
               end
            end
         end
         S_RD: begin
            if (word_q == LAST) state_d = S_FINAL;
            else                word_d  = word_q + WAW'(1);
         end
         S_FINAL: state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase

      if (stop) state_d = S_DONE;

      // registered port values for the operation chosen for next cycle
      en_d    = 1'b0;
      we_d    = 1'b0;
      be_d    = '0;
      addr_d  = '0;
      wdata_d = '0;
      case (state_d)
         S_WR: begin
            en_d   = 1'b1;
            we_d   = 1'b1;
            be_d   = '1;
            addr_d = {word_d, 2'b00};
         end
         S_RW: begin
            en_d   = 1'b1;
            be_d   = '1;
            addr_d = {word_d, 2'b00};
            if (!rd_d) begin
               we_d    = 1'b1;
               wdata_d = elem_d[0] ? '1 : '0;
            end
         end
         S_RD: begin
            en_d   = 1'b1;
            be_d   = '1;
            addr_d = {word_d, 2'b00};
         end
         default: ;
      endcase
      done_d   = (state_d == S_DONE);
      active_d = (state_d != S_IDLE) && (state_d != S_DONE);
   end

   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q     <= S_IDLE;
         elem_q      <= '0;
         word_q      <= '0;
         rd_q        <= 1'b0;
         chk_valid_q <= 1'b0;
         exp_q       <= '0;
         chk_addr_q  <= '0;
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
         done_q      <= 1'b0;
         active_q    <= 1'b0;
         en_q        <= 1'b0;
         we_q        <= 1'b0;
         be_q        <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         elem_q      <= elem_d;
         word_q      <= word_d;
         rd_q        <= rd_d;
         chk_valid_q <= chk_valid_d;
         exp_q       <= exp_d;
         chk_addr_q  <= chk_addr_d;
         fail_q      <= fail_d;
         fail_addr_q <= fail_addr_d;
         done_q      <= done_d;
         active_q    <= active_d;
         en_q        <= en_d;
         we_q        <= we_d;
         be_q        <= be_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
      end
   end

   assign bist_active_o = active_q;
   assign done_o        = done_q;
   assign fail_o        = fail_q;
   assign fail_addr_o   = fail_addr_q;
   assign ram.en        = en_q;
   assign ram.we        = we_q;
   assign ram.be        = be_q;
   assign ram.addr      = addr_q;
   assign ram.wdata     = wdata_q;
endmodule
